// File: rtl/alu_sequencer.sv
// alu_sequencer: opcode-driven control sequencer for a two-register ALU datapath.
// Defining SEQ_STEP_EN adds a step input that gates the EX1/EX2 advances.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       cf_in,
    input  logic       zf_in,
`ifdef SEQ_STEP_EN
    input  logic       step,
`endif
    output logic       bus_in_en,
    output logic       n_la,
    output logic       n_lb,
    output logic       ea,
    output logic       eu,
    output logic       sub,
    output logic       busy,
    output logic       done,
    output logic       cf,
    output logic       zf,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, EX1, EX2, DONE} state_t;
    state_t     state;
    logic [2:0] op_q;
    logic       adv, ex1, ex2, two_step;
`ifdef SEQ_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif
    assign ex1       = state == EX1;
    assign ex2       = state == EX2;
    assign two_step  = op_q == 3'b011 || op_q == 3'b100;
    assign bus_in_en = ex1 && (op_q == 3'b001 || op_q == 3'b010 || two_step);
    assign n_la      = !((ex1 && op_q == 3'b001) || (ex2 && two_step));
    assign n_lb      = !(ex1 && (op_q == 3'b010 || two_step));
    assign ea        = ex1 && op_q == 3'b101;
    assign eu        = ex2 && two_step;
    assign sub       = ex2 && op_q == 3'b100;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= 3'b000;
            cf    <= 1'b0;
            zf    <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q  <= opcode;
                    state <= EX1;
                end
                EX1: if (adv) begin
                    state <= two_step ? EX2 : DONE;
                    if (op_q[2:1] == 2'b11) err <= 1'b1;
                end
                EX2: if (adv) begin
                    state <= DONE;
                    cf    <= cf_in;
                    zf    <= zf_in;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench for alu_sequencer.
module tb_alu_sequencer;
    logic clk = 0, rst_n = 0, start = 0, cf_in = 0, zf_in = 0;
    logic [2:0] opcode = 0;
    logic bus_in_en, n_la, n_lb, ea, eu, sub, busy, done, cf, zf, err;
`ifdef SEQ_STEP_EN
    logic step = 1;
`endif
    int tests = 0, fails = 0;
    bit mon_en = 0, abort_mode = 0;
    typedef struct {logic [2:0] op; logic cf, zf, err;} exp_t;
    exp_t q[$];
    logic m_cf = 0, m_zf = 0, m_err = 0;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .cf_in(cf_in), .zf_in(zf_in),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .bus_in_en(bus_in_en), .n_la(n_la), .n_lb(n_lb), .ea(ea), .eu(eu),
        .sub(sub), .busy(busy), .done(done), .cf(cf), .zf(zf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_alu(input logic [2:0] op);
        return op == 3'd3 || op == 3'd4;
    endfunction

    // Expected {bus_in_en,n_la,n_lb,ea,eu,sub,done} for the k-th busy cycle of op.
    function automatic logic [6:0] exp_ctrl(input logic [2:0] op, input int k);
        int last = is_alu(op) ? 3 : 2;
        if (k == last) return 7'b0110001;
        if (k == 2 && is_alu(op)) return op == 3'd4 ? 7'b0010110 : 7'b0010100;
        if (k != 1) return 7'b0110000;
        case (op)
            3'd1: return 7'b1010000;
            3'd2, 3'd3, 3'd4: return 7'b1100000;
            3'd5: return 7'b0111000;
            default: return 7'b0110000;
        endcase
    endfunction

    function automatic logic [6:0] ctrl();
        return {bus_in_en, n_la, n_lb, ea, eu, sub, done};
    endfunction

    int k = 0;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("bus_onehot", 8'(int'(bus_in_en) + int'(ea) + int'(eu) > 1), 8'd0);
            if (abort_mode) begin
                if (done) chk("abort_done", 8'(done), 8'd0);
            end else if (!busy) begin
                k = 0;
                chk("idle_ctrl", 8'(ctrl()), 8'(7'b0110000));
            end else if (q.size() == 0) begin
                chk("spurious_busy", 8'(busy), 8'd0);
            end else begin
                k++;
                chk($sformatf("ctrl_op%0d_k%0d", q[0].op, k), 8'(ctrl()), 8'(exp_ctrl(q[0].op, k)));
                if (k > (is_alu(q[0].op) ? 3 : 2)) chk("latency_overrun", 8'(k), 8'(is_alu(q[0].op) ? 3 : 2));
                if (done) begin
                    chk("done_flags", {5'd0, cf, zf, err}, {5'd0, q[0].cf, q[0].zf, q[0].err});
                    void'(q.pop_front());
                    k = 0;
                end
            end
        end
    end

    initial begin
        int nops;
        logic [2:0] op;
        rst_n = 0; start = 1; opcode = 3'd1;
        @(posedge clk); #1;
        chk("rst_ctrl", 8'(ctrl()), 8'(7'b0110000));
        chk("rst_state", {3'd0, busy, done, cf, zf, err}, 8'd0);
        rst_n = 1; start = 0; mon_en = 1;
        @(posedge clk); #1;
        chk("rst_start_ignored", 8'(busy), 8'd0);
        nops = 200;
        for (int i = 0; i < nops; i++) begin
            op = 3'($urandom_range(0, 7));
            if (i < 8) op = 3'(i);
            start = 1; opcode = op;
            cf_in = 1'($urandom); zf_in = 1'($urandom);
            if (is_alu(op)) begin m_cf = cf_in; m_zf = zf_in; end
            if (op >= 3'd6) m_err = 1;
            q.push_back('{op, m_cf, m_zf, m_err});
            @(posedge clk); #1;
            repeat (is_alu(op) ? 3 : 2) begin
                start = 1'($urandom); opcode = 3'($urandom);
                @(posedge clk); #1;
            end
            start = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        repeat (6) begin @(posedge clk); #1; end
        chk("queue_drained", 8'(q.size()), 8'd0);
        abort_mode = 1;
`ifdef SEQ_STEP_EN
        start = 1; opcode = 3'd3; step = 0;
        @(posedge clk); #1;
        start = 0;
        repeat (5) begin
            chk("step_freeze", 8'(ctrl()), 8'(7'b1100000));
            @(posedge clk); #1;
        end
        step = 1;
        @(posedge clk); #1;
        chk("step_ex2", 8'(ctrl()), 8'(7'b0010100));
        repeat (3) begin @(posedge clk); #1; end
`endif
        start = 1; opcode = 3'd3; cf_in = 1; zf_in = 1;
        @(posedge clk); #1;
        start = 0; opcode = 3'd4;
        chk("abort_ex1", 8'(ctrl()), 8'(7'b1100000));
        @(posedge clk); #1;
        chk("abort_ex2", 8'(ctrl()), 8'(7'b0010100));
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort_state", {3'd0, busy, done, cf, zf, err}, 8'd0);
        chk("abort_ctrl", 8'(ctrl()), 8'(7'b0110000));
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_idle", 8'(busy), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
